// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared state type and width helpers for the i2c master arbiter
package i2c_arb_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int timeout_w(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction
endpackage

// File: rtl/i2c_master_arbiter_if.sv
// i2c_master_arbiter_if: requester-side and i2c_master-side signals of the arbiter
interface i2c_master_arbiter_if #(parameter int NUM_REQ = 2);
    logic [NUM_REQ-1:0]   req, gnt, timeout_err;
    logic [NUM_REQ*8-1:0] r_address, r_data_tx;
    logic [NUM_REQ-1:0]   r_transfer_start, r_transfer_continues;
    logic [NUM_REQ-1:0]   r_transfer_ready, r_interrupt, r_transaction_complete, r_nack, r_address_err;
    logic [7:0]           r_data_rx, m_address, m_data_tx, m_data_rx;
    logic                 m_transfer_start, m_transfer_continues;
    logic                 m_transfer_ready, m_interrupt, m_transaction_complete, m_nack, m_address_err;
    logic                 busy;

    modport master (
        input  req, r_address, r_data_tx, r_transfer_start, r_transfer_continues,
               m_transfer_ready, m_interrupt, m_transaction_complete, m_nack, m_address_err, m_data_rx,
        output gnt, timeout_err, busy, r_transfer_ready, r_interrupt, r_transaction_complete,
               r_nack, r_address_err, r_data_rx, m_address, m_data_tx, m_transfer_start, m_transfer_continues
    );

    modport slave (
        output req, r_address, r_data_tx, r_transfer_start, r_transfer_continues,
               m_transfer_ready, m_interrupt, m_transaction_complete, m_nack, m_address_err, m_data_rx,
        input  gnt, timeout_err, busy, r_transfer_ready, r_interrupt, r_transaction_complete,
               r_nack, r_address_err, r_data_rx, m_address, m_data_tx, m_transfer_start, m_transfer_continues
    );
endinterface

// File: rtl/i2c_master_arbiter_rr_picker.sv
// rr_picker: picks the first eligible index strictly after last_grant, wrapping
module rr_picker
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   index,
    output logic               any_valid
);
    logic [IDX_W-1:0] cand;

    always_comb begin
        winner    = '0;
        index     = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (!any_valid && eligible[cand]) begin
                any_valid = 1'b1;
                index     = cand;
            end
        end
        winner[index] = any_valid;
    end
endmodule

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: round-robin sharing of one i2c_master among NUM_REQ requesters,
// whole-transaction grants, response routing to the owner and grant revocation on timeout
module i2c_master_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input logic                  clk_in,
    input logic                  reset_n,
    i2c_master_arbiter_if.master bus
);
    localparam int IDX_W     = idx_w(NUM_REQ);
    localparam int TIMEOUT_W = timeout_w(TIMEOUT_CYCLES);

    arb_state_t           state, state_n;
    logic [NUM_REQ-1:0]   gnt_n, mask, mask_n, tmo_n, elig, win;
    logic [IDX_W-1:0]     last, last_n, pick;
    logic [TIMEOUT_W-1:0] cnt, cnt_n;
    logic [7:0]           addr_q, data_q;
    logic                 any, req_g, tmo_hit, granted;

    rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .eligible  (elig),
        .last_grant(last),
        .winner    (win),
        .index     (pick),
        .any_valid (any)
    );

    assign elig    = bus.req & ~mask;
    assign req_g   = |(bus.req & bus.gnt);
    assign granted = state == GRANT;
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1) && !bus.m_interrupt;

    always_comb begin
        state_n = state;
        gnt_n   = bus.gnt;
        last_n  = last;
        cnt_n   = cnt;
        tmo_n   = '0;
        mask_n  = mask & bus.req;
        case (state)
            IDLE: if (any && bus.m_transfer_ready) begin
                state_n = GRANT;
                gnt_n   = win;
                last_n  = pick;
                cnt_n   = '0;
            end
            GRANT: begin
                cnt_n = bus.m_interrupt ? '0 : cnt + 1'b1;
                if (!req_g) begin
                    state_n = bus.m_transfer_ready ? IDLE : DRAIN;
                    gnt_n   = '0;
                end else if (tmo_hit) begin
                    state_n = DRAIN;
                    gnt_n   = '0;
                    tmo_n   = bus.gnt;
                    mask_n  = mask_n | bus.gnt;
                end
            end
            default: if (bus.m_transfer_ready) state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            bus.gnt         <= '0;
            last            <= IDX_W'(NUM_REQ - 1);
            cnt             <= '0;
            mask            <= '0;
            bus.timeout_err <= '0;
            addr_q          <= '0;
            data_q          <= '0;
        end else begin
            state           <= state_n;
            bus.gnt         <= gnt_n;
            last            <= last_n;
            cnt             <= cnt_n;
            mask            <= mask_n;
            bus.timeout_err <= tmo_n;
            addr_q          <= bus.m_address;
            data_q          <= bus.m_data_tx;
        end
    end

    // Outside GRANT the address/data bytes freeze so the master can finish its byte and STOP
    assign bus.m_address              = granted ? bus.r_address[{last, 3'b000} +: 8] : addr_q;
    assign bus.m_data_tx              = granted ? bus.r_data_tx[{last, 3'b000} +: 8] : data_q;
    assign bus.m_transfer_start       = granted && bus.r_transfer_start[last];
    assign bus.m_transfer_continues   = granted && bus.r_transfer_continues[last];
    assign bus.r_transfer_ready       = bus.gnt & {NUM_REQ{bus.m_transfer_ready}};
    assign bus.r_interrupt            = bus.gnt & {NUM_REQ{bus.m_interrupt}};
    assign bus.r_transaction_complete = bus.gnt & {NUM_REQ{bus.m_transaction_complete}};
    assign bus.r_nack                 = bus.gnt & {NUM_REQ{bus.m_nack}};
    assign bus.r_address_err          = bus.gnt & {NUM_REQ{bus.m_address_err}};
    assign bus.r_data_rx              = bus.m_data_rx;
    assign bus.busy                   = state != IDLE;
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb_i2c_master_arbiter: directed stimulus checked every cycle against a behavioural ownership model
module tb_i2c_master_arbiter;
    localparam int N = 2;
    localparam int T = 16;

    logic clk_in  = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp   = 0;
    int   n_bad   = 0;

    i2c_master_arbiter_if #(.NUM_REQ(N)) bus ();

    i2c_master_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .clk_in (clk_in),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    // Model: who owns the bus (-1 = nobody), whether the master is draining, and round-robin history
    int         owner, last, quiet, c;
    bit         draining;
    bit [N-1:0] masked, tmo;
    logic [7:0] held_addr, held_data;
    logic [N-1:0] eg;

    function automatic logic [7:0] byte_of(input logic [N*8-1:0] v, input int i);
        return v[8*i +: 8];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            owner = -1; last = N - 1; quiet = 0; draining = 0;
            masked = '0; tmo = '0; held_addr = '0; held_data = '0;
        end else begin
            tmo    = '0;
            masked = masked & bus.req;
            if (owner >= 0) begin
                held_addr = byte_of(bus.r_address, owner);
                held_data = byte_of(bus.r_data_tx, owner);
                if (!bus.req[owner]) begin
                    draining = !bus.m_transfer_ready;
                    owner    = -1;
                end else if (quiet == T - 1 && !bus.m_interrupt) begin
                    tmo[owner]    = 1'b1;
                    masked[owner] = 1'b1;
                    draining      = 1'b1;
                    owner         = -1;
                end else begin
                    quiet = bus.m_interrupt ? 0 : quiet + 1;
                end
            end else if (draining) begin
                draining = !bus.m_transfer_ready;
            end else if (bus.m_transfer_ready) begin
                for (int k = 1; k <= N; k++) begin
                    c = (last + k) % N;
                    if (owner < 0 && bus.req[c] && !masked[c]) begin
                        owner = c; last = c; quiet = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk_in) begin
        if (reset_n) begin
            eg = (owner >= 0) ? N'(1) << owner : '0;
            chk("gnt", bus.gnt, eg);
            chk("busy", bus.busy, owner >= 0 || draining);
            chk("timeout_err", bus.timeout_err, tmo);
            chk("m_address", bus.m_address, owner >= 0 ? byte_of(bus.r_address, owner) : held_addr);
            chk("m_data_tx", bus.m_data_tx, owner >= 0 ? byte_of(bus.r_data_tx, owner) : held_data);
            chk("m_transfer_start", bus.m_transfer_start, owner >= 0 ? bus.r_transfer_start[owner] : 1'b0);
            chk("m_transfer_continues", bus.m_transfer_continues, owner >= 0 ? bus.r_transfer_continues[owner] : 1'b0);
            chk("r_transfer_ready", bus.r_transfer_ready, eg & {N{bus.m_transfer_ready}});
            chk("r_interrupt", bus.r_interrupt, eg & {N{bus.m_interrupt}});
            chk("r_transaction_complete", bus.r_transaction_complete, eg & {N{bus.m_transaction_complete}});
            chk("r_nack", bus.r_nack, eg & {N{bus.m_nack}});
            chk("r_address_err", bus.r_address_err, eg & {N{bus.m_address_err}});
            chk("r_data_rx", bus.r_data_rx, bus.m_data_rx);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #2;
        end
    endtask

    initial begin
        bus.req = '0; bus.r_address = '0; bus.r_data_tx = '0;
        bus.r_transfer_start = '0; bus.r_transfer_continues = '0;
        bus.m_transfer_ready = 1'b1; bus.m_interrupt = 1'b0; bus.m_transaction_complete = 1'b0;
        bus.m_nack = 1'b0; bus.m_address_err = 1'b0; bus.m_data_rx = 8'h5a;
        tick(2);
        @(negedge clk_in);
        chk("rst_gnt", bus.gnt, 2'b00);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_m_address", bus.m_address, 8'h00);
        reset_n = 1'b1;
        tick(1);
        bus.req = 2'b11;
        bus.r_address = {8'h6c, 8'h42};
        bus.r_data_tx = {8'h30, 8'h99};
        bus.r_transfer_start = 2'b11;
        bus.r_transfer_continues = 2'b11;
        tick(1);
        @(negedge clk_in);
        chk("t1_first_gnt", bus.gnt, 2'b01);
        chk("t1_m_address", bus.m_address, 8'h42);
        tick(1);
        bus.m_interrupt = 1'b1; bus.m_nack = 1'b1;
        @(negedge clk_in);
        chk("t6_r_nack", bus.r_nack, 2'b01);
        chk("t6_r_interrupt", bus.r_interrupt, 2'b01);
        chk("t6_gnt", bus.gnt, 2'b01);
        tick(1);
        bus.m_interrupt = 1'b0; bus.m_nack = 1'b0; bus.m_transfer_ready = 1'b0;
        tick(3);
        bus.m_transfer_ready = 1'b1; bus.req = 2'b10;
        tick(1);
        @(negedge clk_in);
        chk("t1_release", bus.gnt, 2'b00);
        tick(1);
        @(negedge clk_in);
        chk("t1_second_gnt", bus.gnt, 2'b10);
        chk("t2_m_address", bus.m_address, 8'h6c);
        chk("t2_m_data_tx", bus.m_data_tx, 8'h30);
        tick(1);
        bus.r_data_tx = {8'h0a, 8'h99};
        bus.m_interrupt = 1'b1; bus.m_transaction_complete = 1'b1; bus.m_data_rx = 8'hc3;
        @(negedge clk_in);
        chk("t2_m_data_tx_b", bus.m_data_tx, 8'h0a);
        chk("t2_r_interrupt", bus.r_interrupt, 2'b10);
        chk("t2_r_data_rx", bus.r_data_rx, 8'hc3);
        tick(1);
        bus.m_interrupt = 1'b0; bus.m_transaction_complete = 1'b0; bus.req = 2'b11;
        tick(2);
        bus.req = 2'b01;
        tick(1);
        @(negedge clk_in);
        chk("t1_gap", bus.gnt, 2'b00);
        tick(1);
        @(negedge clk_in);
        chk("t1_rerequest", bus.gnt, 2'b01);
        tick(15);
        @(negedge clk_in);
        chk("t3_pre_tmo", bus.timeout_err, 2'b00);
        chk("t3_pre_gnt", bus.gnt, 2'b01);
        tick(1);
        @(negedge clk_in);
        chk("t3_tmo_pulse", bus.timeout_err, 2'b01);
        chk("t3_tmo_gnt", bus.gnt, 2'b00);
        chk("t3_tmo_busy", bus.busy, 1'b1);
        tick(1);
        @(negedge clk_in);
        chk("t3_tmo_clear", bus.timeout_err, 2'b00);
        tick(3);
        @(negedge clk_in);
        chk("t3_masked", bus.gnt, 2'b00);
        bus.req = 2'b00;
        tick(1);
        bus.req = 2'b01;
        tick(1);
        @(negedge clk_in);
        chk("t3_regrant", bus.gnt, 2'b01);
        bus.m_transfer_ready = 1'b0;
        tick(2);
        bus.req = 2'b00;
        tick(1);
        @(negedge clk_in);
        chk("t4_drain_gnt", bus.gnt, 2'b00);
        chk("t4_drain_busy", bus.busy, 1'b1);
        chk("t4_drain_start", bus.m_transfer_start, 1'b0);
        chk("t4_drain_addr", bus.m_address, 8'h42);
        bus.req = 2'b10;
        tick(2);
        @(negedge clk_in);
        chk("t4_still_drain", bus.busy, 1'b1);
        bus.m_transfer_ready = 1'b1;
        tick(1);
        @(negedge clk_in);
        chk("t4_no_early_gnt", bus.gnt, 2'b00);
        tick(1);
        @(negedge clk_in);
        chk("t4_next_gnt", bus.gnt, 2'b10);
        #1 reset_n = 1'b0;
        #1;
        chk("t5_gnt", bus.gnt, 2'b00);
        chk("t5_start", bus.m_transfer_start, 1'b0);
        chk("t5_cont", bus.m_transfer_continues, 1'b0);
        chk("t5_tmo", bus.timeout_err, 2'b00);
        chk("t5_busy", bus.busy, 1'b0);
        tick(1);
        bus.req = 2'b11;
        reset_n = 1'b1;
        tick(1);
        @(negedge clk_in);
        chk("t5_prio0", bus.gnt, 2'b01);
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
